s3_result_capture: RTL

Downstream stage 3 of the two-stage slow/fast pipeline: consumes the stage-2 random-delay output `s2_result`, waits a fixed settle window after each `slow_clk` rising edge, then captures the settled value into a small FIFO. Captured samples are handed off on a valid/ready interface and folded into a running 16-bit sum. It runs entirely on `fast_clk`. `slow_clk` is the divided clock produced by `pipeline_top` and is treated here as a synchronous data input, never as a clock.

---
 rtl/s3_result_capture_pkg.sv | 13 +
 rtl/s3_result_capture_fifo.sv | 50 +++++
 rtl/s3_result_capture.sv | 129 ++++++++++++
 3 files changed

// File: rtl/s3_result_capture_pkg.sv
// rtl/s3_result_capture_pkg.sv - shared types and constants for the stage-3 capture block
package s3_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int SUM_W      = 16;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/s3_result_capture_fifo.sv
// rtl/s3_result_capture_fifo.sv - show-ahead synchronous FIFO with wrap-bit pointers
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_pop;
  logic              do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A same-cycle pop frees the slot, so a push on full is still taken.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/s3_result_capture.sv
// rtl/s3_result_capture.sv - settle-then-capture of stage-2 results into a FIFO with running sum
module s3_result_capture
  import s3_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SETTLE_CYC = 4,
  parameter int DEPTH      = 8
) (
  input  logic                   fast_clk,
  input  logic                   rst,
  input  logic                   slow_clk,
  input  logic [DATA_W-1:0]      s2_result,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [SUM_W-1:0]       sum,
  output logic                   overflow,
  output logic                   err_miss
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic              slow_q;
  logic              rise;
  logic              push;
  logic              miss;
  logic              pop;
  logic              accept;
  logic              full;
  logic              empty;

  // slow_clk is only ever data here; its rising edge is found by comparison.
  assign rise = slow_clk & ~slow_q;

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      slow_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      slow_q <= slow_clk;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = SETTLE;
          cnt_nx   = CNT_LOAD;
        end
      end
      SETTLE: begin
        if (rise) begin
          cnt_nx = CNT_LOAD;
        end else if (cnt == '0) begin
          state_nx = CAPTURE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      CAPTURE: begin
        if (rise) begin
          state_nx = SETTLE;
          cnt_nx   = CNT_LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    push = (state == CAPTURE);
    miss = rise & ((state == SETTLE) | (state == CAPTURE));
  end

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign accept    = push & (~full | pop);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (fast_clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_ready),
    .din   (s2_result),
    .dout  (out_data),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      sum      <= '0;
      overflow <= 1'b0;
      err_miss <= 1'b0;
    end else begin
      if (miss) begin
        err_miss <= 1'b1;
      end
      if (push & ~accept) begin
        overflow <= 1'b1;
      end
      if (accept) begin
        sum <= sum + SUM_W'(s2_result);
      end
    end
  end

endmodule
